// File: rtl/muldiv_unit_if.sv
// Execute-stage <-> HI/LO unit bundle: op request, flush, stall/done status and HI/LO.
interface muldiv_unit_if;
  logic        valid_i;
  logic [2:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        flush_i;
  logic        stall_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport master (output valid_i, op_i, a_i, b_i, flush_i,
                  input  stall_o, busy_o, done_o, hi_o, lo_o);
  modport slave  (input  valid_i, op_i, a_i, b_i, flush_i,
                  output stall_o, busy_o, done_o, hi_o, lo_o);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit (shift-add multiply, restoring divide).
// Optional MULDIV_FAST_MUL_EN: single-cycle MULT/MULTU; divide always iterative.
module muldiv_unit (
  input  logic         clk,
  input  logic         resetn,
  muldiv_unit_if.slave bus
);
  // state | meaning
  // IDLE  | waiting for an op; MTHI/MTLO write directly
  // MUL   | one shift-add step per cycle, 32 steps
  // DIV   | one restoring-divide step per cycle, 32 steps
  // DONE  | sign-correct and commit HI/LO, pulse done_o
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opb_q, opb_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        neg_q, neg_d, rneg_q, rneg_d, is_div_q, is_div_d;
  logic        stall, done;

  logic        sx;
  logic [31:0] a_mag, b_mag;
  assign sx    = (bus.op_i == OP_MULT) || (bus.op_i == OP_DIV);
  assign a_mag = (sx && bus.a_i[31]) ? (~bus.a_i + 32'd1) : bus.a_i;
  assign b_mag = (sx && bus.b_i[31]) ? (~bus.b_i + 32'd1) : bus.b_i;

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opb_q : 32'd0)};
  assign mul_next = {mul_sum, acc_q[31:1]};

  logic [32:0] div_cand;
  logic        div_ge;
  logic [63:0] div_next;
  assign div_cand = acc_q[63:31];
  assign div_ge   = (div_cand >= {1'b0, opb_q});
  assign div_next = {(div_ge ? (div_cand[31:0] - opb_q) : div_cand[31:0]),
                     acc_q[30:0], div_ge};

  logic [63:0] mul_res;
  logic [31:0] quo_res, rem_res;
  assign mul_res = neg_q  ? (~acc_q + 64'd1)         : acc_q;
  assign quo_res = neg_q  ? (~acc_q[31:0] + 32'd1)   : acc_q[31:0];
  assign rem_res = rneg_q ? (~acc_q[63:32] + 32'd1)  : acc_q[63:32];

`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] fast_prod;
  assign fast_prod = {{32{sx & bus.a_i[31]}}, bus.a_i} * {{32{sx & bus.b_i[31]}}, bus.b_i};
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    is_div_d = is_div_q;
    stall    = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.valid_i && !bus.flush_i) begin
          case (bus.op_i)
`ifdef MULDIV_FAST_MUL_EN
            OP_MULT, OP_MULTU: begin
              hi_d = fast_prod[63:32];
              lo_d = fast_prod[31:0];
              done = 1'b1;
            end
`else
            OP_MULT, OP_MULTU: begin
              stall    = 1'b1;
              acc_d    = {32'd0, a_mag};
              opb_d    = b_mag;
              neg_d    = sx & (bus.a_i[31] ^ bus.b_i[31]);
              rneg_d   = 1'b0;
              is_div_d = 1'b0;
              cnt_d    = 5'd0;
              state_d  = MUL;
            end
`endif
            OP_DIV, OP_DIVU: begin
              stall    = 1'b1;
              acc_d    = {32'd0, a_mag};
              opb_d    = b_mag;
              neg_d    = sx & (bus.a_i[31] ^ bus.b_i[31]);
              rneg_d   = sx & bus.a_i[31];
              is_div_d = 1'b1;
              cnt_d    = 5'd0;
              state_d  = DIV;
            end
            OP_MTHI: hi_d = bus.a_i;
            OP_MTLO: lo_d = bus.a_i;
            default: ;
          endcase
        end
      end
      MUL, DIV: begin
        if (bus.flush_i) begin
          state_d = IDLE;
        end else begin
          stall = 1'b1;
          acc_d = (state_q == MUL) ? mul_next : div_next;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = DONE;
        end
      end
      DONE: begin
        // valid_i is ignored here: the held instruction must not restart
        state_d = IDLE;
        if (!bus.flush_i) begin
          done = 1'b1;
          hi_d = is_div_q ? rem_res : mul_res[63:32];
          lo_d = is_div_q ? quo_res : mul_res[31:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      acc_q    <= 64'd0;
      opb_q    <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      is_div_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      is_div_q <= is_div_d;
    end
  end

  assign bus.stall_o = stall & resetn;
  assign bus.done_o  = done & resetn;
  assign bus.busy_o  = (state_q != IDLE);
  assign bus.hi_o    = hi_q;
  assign bus.lo_o    = lo_q;
endmodule
